ex_stage_muldiv: RTL and testbench
==================================

# ex_stage_muldiv

Parametrised, registered MIPS execute stage. It selects ALU operands, decodes Opcode/Funct, and computes single-cycle ALU results, the branch target and the destination register. It adds a multi-cycle multiply/divide unit with HI/LO registers and a stall handshake. It sits between the ID/EX register and the memory stage, and drives an EX/MEM output register with a valid bit.

## Interface
Parameters:
- DATA_W, 32: datapath width. Must be a power of two, ≥ 16.
- REG_ADDR_W, 5: register-file address width.
- MUL_CYCLES, 4: fixed multiply latency in cycles, ≥ 1.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  instruction presented this cycle.
- Flush  in  1  drops the presented instruction.
- Opcode, Funct  in  6 each  instruction fields.
- ALUSrcA  in  1  selects A operand: 0 = Reg_Data1, 1 = zero-extended sa.
- ALUSrcB  in  2  selects B operand: 0 = Reg_Data2, 1 = Imm32b, 2 = constant 8, 3 = 0.
- RegDst  in  1  selects destination: 0 = rt, 1 = rd.
- RegWrite  in  1  writeback enable, passed through.
- Reg_Data1, Reg_Data2, Imm32b, PC_Plus4  in  DATA_W each  operands.
- sa  in  5  shift amount.
- rt, rd  in  REG_ADDR_W each  destination candidates.
- Stall  out  1  hold upstream; the presented instruction is not accepted.
- out_valid  out  1  EX/MEM entry valid.
- ALUResult_out, PC_Plus_Branch_out  out  DATA_W each  registered results.
- Zero_out  out  1  registered (ALU result == 0).
- RegDest_out  out  REG_ADDR_W  registered selected destination.
- RegWrite_out  out  1  registered writeback enable.

## Operation
- **Accept condition:** the presented instruction is accepted when in_valid & ~Flush & ~Stall.
- **Decode:** implemented by a pure combinational function.
  - Opcode 0 by Funct: ADD/ADDU 0x20/0x21, SUB/SUBU 0x22/0x23, AND 0x24, OR 0x25, XOR 0x26, NOR 0x27, SLT 0x2A, SLTU 0x2B, SLL 0x00, SRL 0x02, SRA 0x03, MFHI 0x10, MFLO 0x12, MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B.
  - By Opcode: ADDI/ADDIU 0x08/0x09, SLTI 0x0A, SLTIU 0x0B, ANDI 0x0C, ORI 0x0D, XORI 0x0E, LUI 0x0F.
  - LW 0x23 and SW 0x2B perform ADD; BEQ 0x04 and BNE 0x05 perform SUB.
  - MUL is Opcode 0x1C with Funct 0x02.
  - Any other encoding produces result 0.
- **Arithmetic:** results wrap modulo 2^DATA_W; there is no overflow trap.
  - Shifts move B by A[log2(DATA_W)-1:0].
  - LUI produces B << 16.
  - SLT/SLTI compare signed; SLTU/SLTIU compare unsigned.
- **Branch target:** PC_Plus_Branch = PC_Plus4 + (Imm32b << 2), truncated to DATA_W. It is computed for every instruction.
- **FSM states:** IDLE, MUL_BUSY, DIV_BUSY.
- **Multiply:** an accepted MULT, MULTU or MUL moves IDLE→MUL_BUSY.
  - It runs MUL_CYCLES cycles.
  - It writes the 2·DATA_W product: HI = upper word, LO = lower word.
  - It then returns to IDLE.
- **Divide:** an accepted DIV or DIVU moves IDLE→DIV_BUSY.
  - The divider is iterative restoring and runs DATA_W cycles.
  - LO = quotient, truncated toward zero. HI = remainder, carrying the sign of the dividend.
  - Divide by 0: LO = all ones, HI = dividend.
  - Signed MIN / −1: LO = MIN, HI = 0.
- **Stall:** Stall = (state ≠ IDLE). While Stall is high, inputs are ignored and upstream holds.
- **Writeback of mul/div ops:**
  - MULT, MULTU, DIV and DIVU emit a bubble on acceptance: out_valid = 1, RegWrite_out = 0.
  - MUL emits nothing on acceptance. On completion it emits out_valid = 1 with ALUResult_out = low product word and its latched RegDest/RegWrite.
- **MFHI/MFLO:** read HI/LO in IDLE only. A pending op keeps Stall high, so they are never accepted while busy.
- **Flush:** suppresses only the presented instruction; out_valid = 0 next cycle. It never aborts an in-flight multiply or divide.
- **Cycles with no accept and no MUL completion:** out_valid = 0 and RegWrite_out = 0. The data outputs hold their previous values.

## Timing
- **Reset values:** state IDLE, HI = LO = 0, Stall = 0, out_valid = 0, RegWrite_out = 0, ALUResult_out = 0, PC_Plus_Branch_out = 0, Zero_out = 0, RegDest_out = 0.
- **Single-cycle ops:** accepted at edge N, outputs valid after edge N.
- **Multiply:** Stall is high for exactly MUL_CYCLES cycles, starting the cycle after acceptance. HI/LO update on the final edge. A MUL's out_valid rises on that same edge.
- **Divide:** Stall is high for DATA_W cycles; HI/LO update on the final edge.
- **Back-to-back:** an instruction held during Stall is accepted on the first cycle Stall is low.
- **Reset mid-operation:** asserting Reset mid-operation aborts immediately. State returns to IDLE and HI/LO clear.

## Structure
- Package ex_pkg holds:
  - the opcode and funct localparams;
  - the ALU op enum (ADD, SUB, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, LUI, MFHI, MFLO, MULT, MULTU, DIV, DIVU, MUL, NOP);
  - the FSM state enum.
- One sub-module, ex_muldiv_unit, contains the FSM, counter, product/divide registers and HI/LO. Its interface is start/op/operands in, and busy/done/HI/LO out.
- The decode function, operand muxes and ALU stay in the top module.

## Test plan
- ADDI with Reg_Data1 = 5, Imm32b = 0xFFFFFFFF, ALUSrcB = 1 → one cycle later ALUResult_out = 4, Zero_out = 0, out_valid = 1.
- SRA with ALUSrcA = 1, sa = 4, Reg_Data2 = 0x80000000 → 0xF8000000. SLTU with 1 vs 0xFFFFFFFF → 1.
- MULT 0xFFFFFFFF × 2 (signed), MUL_CYCLES = 4 → Stall high for 4 cycles. Then MFHI returns 0xFFFFFFFF and MFLO returns 0xFFFFFFFE.
- DIV −7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF, Stall high for 32 cycles. DIVU 9 / 0 → LO = 0xFFFFFFFF, HI = 9.
- MUL 3 × 4 with rd = 7 and Flush asserted during the busy period → out_valid only at completion, ALUResult_out = 12, RegDest_out = 7.
- Reset dropped during DIV_BUSY → Stall = 0, HI = LO = 0, out_valid = 0 immediately.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared encodings and types for the MIPS execute stage with multiply/divide.
package ex_pkg;

  localparam int unsigned OPC_W = 6;
  localparam int unsigned SA_W  = 5;

  localparam logic [OPC_W-1:0] OPC_RTYPE    = 6'h00;
  localparam logic [OPC_W-1:0] OPC_BEQ      = 6'h04;
  localparam logic [OPC_W-1:0] OPC_BNE      = 6'h05;
  localparam logic [OPC_W-1:0] OPC_ADDI     = 6'h08;
  localparam logic [OPC_W-1:0] OPC_ADDIU    = 6'h09;
  localparam logic [OPC_W-1:0] OPC_SLTI     = 6'h0A;
  localparam logic [OPC_W-1:0] OPC_SLTIU    = 6'h0B;
  localparam logic [OPC_W-1:0] OPC_ANDI     = 6'h0C;
  localparam logic [OPC_W-1:0] OPC_ORI      = 6'h0D;
  localparam logic [OPC_W-1:0] OPC_XORI     = 6'h0E;
  localparam logic [OPC_W-1:0] OPC_LUI      = 6'h0F;
  localparam logic [OPC_W-1:0] OPC_SPECIAL2 = 6'h1C;
  localparam logic [OPC_W-1:0] OPC_LW       = 6'h23;
  localparam logic [OPC_W-1:0] OPC_SW       = 6'h2B;

  localparam logic [OPC_W-1:0] FN_SLL   = 6'h00;
  localparam logic [OPC_W-1:0] FN_SRL   = 6'h02;
  localparam logic [OPC_W-1:0] FN_SRA   = 6'h03;
  localparam logic [OPC_W-1:0] FN_MFHI  = 6'h10;
  localparam logic [OPC_W-1:0] FN_MFLO  = 6'h12;
  localparam logic [OPC_W-1:0] FN_MULT  = 6'h18;
  localparam logic [OPC_W-1:0] FN_MULTU = 6'h19;
  localparam logic [OPC_W-1:0] FN_DIV   = 6'h1A;
  localparam logic [OPC_W-1:0] FN_DIVU  = 6'h1B;
  localparam logic [OPC_W-1:0] FN_ADD   = 6'h20;
  localparam logic [OPC_W-1:0] FN_ADDU  = 6'h21;
  localparam logic [OPC_W-1:0] FN_SUB   = 6'h22;
  localparam logic [OPC_W-1:0] FN_SUBU  = 6'h23;
  localparam logic [OPC_W-1:0] FN_AND   = 6'h24;
  localparam logic [OPC_W-1:0] FN_OR    = 6'h25;
  localparam logic [OPC_W-1:0] FN_XOR   = 6'h26;
  localparam logic [OPC_W-1:0] FN_NOR   = 6'h27;
  localparam logic [OPC_W-1:0] FN_SLT   = 6'h2A;
  localparam logic [OPC_W-1:0] FN_SLTU  = 6'h2B;
  localparam logic [OPC_W-1:0] FN2_MUL  = 6'h02;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI, ALU_MFHI, ALU_MFLO, ALU_MULT,
    ALU_MULTU, ALU_DIV, ALU_DIVU, ALU_MUL, ALU_NOP
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE, MUL_BUSY, DIV_BUSY
  } md_state_e;

  function automatic logic is_mul(input alu_op_e op);
    return (op == ALU_MULT) || (op == ALU_MULTU) || (op == ALU_MUL);
  endfunction

  function automatic logic is_div(input alu_op_e op);
    return (op == ALU_DIV) || (op == ALU_DIVU);
  endfunction

endpackage

// File: rtl/ex_muldiv_unit.sv
// Multi-cycle multiply / iterative restoring divide with HI/LO registers.
module ex_muldiv_unit
  import ex_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MUL_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  alu_op_e           op,
  input  logic [DATA_W-1:0] opa,
  input  logic [DATA_W-1:0] opb,
  output logic              busy,
  output logic              done_c,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic [DATA_W-1:0] lo_nxt_c
);

  localparam int unsigned MAX_CYC = (MUL_CYCLES > DATA_W) ? MUL_CYCLES : DATA_W;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
  localparam int unsigned PW      = 2 * DATA_W;

  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]     prod_q, prod_d;
  logic [DATA_W-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, dvd_q, dvd_d;
  logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
  logic              negq_q, negq_d, negr_q, negr_d, dzero_q, dzero_d;
  logic              busy_q, busy_d;

  logic              div_signed, mul_signed, a_neg, b_neg;
  logic [PW-1:0]     a_ext, b_ext, prod_c;
  logic [DATA_W:0]   rem_sh, diff;
  logic [DATA_W-1:0] rem_st, quo_st;

  assign div_signed = (op == ALU_DIV);
  assign mul_signed = (op != ALU_MULTU);
  assign a_neg      = div_signed & opa[DATA_W-1];
  assign b_neg      = div_signed & opb[DATA_W-1];
  assign a_ext      = mul_signed ? {{DATA_W{opa[DATA_W-1]}}, opa} : {{DATA_W{1'b0}}, opa};
  assign b_ext      = mul_signed ? {{DATA_W{opb[DATA_W-1]}}, opb} : {{DATA_W{1'b0}}, opb};
  assign prod_c     = a_ext * b_ext;

  // One restoring step on the magnitudes: shift in the next dividend bit, try subtract.
  always_comb begin
    rem_sh = {rem_q, quo_q[DATA_W-1]};
    diff   = rem_sh - {1'b0, dvs_q};
    rem_st = rem_sh[DATA_W-1:0];
    quo_st = {quo_q[DATA_W-2:0], 1'b0};
    if (!diff[DATA_W]) begin
      rem_st = diff[DATA_W-1:0];
      quo_st = {quo_q[DATA_W-2:0], 1'b1};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    dvd_d   = dvd_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    dzero_d = dzero_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_c  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && is_mul(op)) begin
          prod_d  = prod_c;
          cnt_d   = CNT_W'(MUL_CYCLES - 1);
          state_d = MUL_BUSY;
        end else if (start && is_div(op)) begin
          quo_d   = a_neg ? -opa : opa;
          dvs_d   = b_neg ? -opb : opb;
          rem_d   = '0;
          negq_d  = a_neg ^ b_neg;
          negr_d  = a_neg;
          dzero_d = (opb == '0);
          dvd_d   = opa;
          cnt_d   = CNT_W'(DATA_W - 1);
          state_d = DIV_BUSY;
        end
      end
      MUL_BUSY: begin
        if (cnt_q == '0) begin
          hi_d    = prod_q[PW-1:DATA_W];
          lo_d    = prod_q[DATA_W-1:0];
          done_c  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DIV_BUSY: begin
        rem_d = rem_st;
        quo_d = quo_st;
        if (cnt_q == '0) begin
          // Signs reapplied on the last step; divide-by-zero overrides the iteration.
          lo_d = negq_q ? -quo_st : quo_st;
          hi_d = negr_q ? -rem_st : rem_st;
          if (dzero_q) begin
            lo_d = '1;
            hi_d = dvd_q;
          end
          done_c  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prod_q  <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      dvd_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      dzero_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      dvd_q   <= dvd_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      dzero_q <= dzero_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign lo_nxt_c = lo_d;

endmodule

// File: rtl/ex_stage_muldiv.sv
// Registered MIPS execute stage: decode, operand select, ALU, branch target,
// and hand-off to the multi-cycle multiply/divide unit.
module ex_stage_muldiv
  import ex_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned MUL_CYCLES = 4
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  in_valid,
  input  logic                  Flush,
  input  logic [5:0]            Opcode,
  input  logic [5:0]            Funct,
  input  logic                  ALUSrcA,
  input  logic [1:0]            ALUSrcB,
  input  logic                  RegDst,
  input  logic                  RegWrite,
  input  logic [DATA_W-1:0]     Reg_Data1,
  input  logic [DATA_W-1:0]     Reg_Data2,
  input  logic [DATA_W-1:0]     Imm32b,
  input  logic [DATA_W-1:0]     PC_Plus4,
  input  logic [4:0]            sa,
  input  logic [REG_ADDR_W-1:0] rt,
  input  logic [REG_ADDR_W-1:0] rd,
  output logic                  Stall,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     ALUResult_out,
  output logic [DATA_W-1:0]     PC_Plus_Branch_out,
  output logic                  Zero_out,
  output logic [REG_ADDR_W-1:0] RegDest_out,
  output logic                  RegWrite_out
);

  localparam int unsigned SH_W = $clog2(DATA_W);

  function automatic alu_op_e decode(input logic [5:0] opc, input logic [5:0] fn);
    alu_op_e op;
    op = ALU_NOP;
    case (opc)
      OPC_RTYPE: begin
        case (fn)
          FN_ADD, FN_ADDU: op = ALU_ADD;
          FN_SUB, FN_SUBU: op = ALU_SUB;
          FN_AND:          op = ALU_AND;
          FN_OR:           op = ALU_OR;
          FN_XOR:          op = ALU_XOR;
          FN_NOR:          op = ALU_NOR;
          FN_SLT:          op = ALU_SLT;
          FN_SLTU:         op = ALU_SLTU;
          FN_SLL:          op = ALU_SLL;
          FN_SRL:          op = ALU_SRL;
          FN_SRA:          op = ALU_SRA;
          FN_MFHI:         op = ALU_MFHI;
          FN_MFLO:         op = ALU_MFLO;
          FN_MULT:         op = ALU_MULT;
          FN_MULTU:        op = ALU_MULTU;
          FN_DIV:          op = ALU_DIV;
          FN_DIVU:         op = ALU_DIVU;
          default:         op = ALU_NOP;
        endcase
      end
      OPC_ADDI, OPC_ADDIU, OPC_LW, OPC_SW: op = ALU_ADD;
      OPC_BEQ, OPC_BNE:                    op = ALU_SUB;
      OPC_SLTI:                            op = ALU_SLT;
      OPC_SLTIU:                           op = ALU_SLTU;
      OPC_ANDI:                            op = ALU_AND;
      OPC_ORI:                             op = ALU_OR;
      OPC_XORI:                            op = ALU_XOR;
      OPC_LUI:                             op = ALU_LUI;
      OPC_SPECIAL2:                        op = (fn == FN2_MUL) ? ALU_MUL : ALU_NOP;
      default:                             op = ALU_NOP;
    endcase
    return op;
  endfunction

  alu_op_e               alu_op;
  logic [DATA_W-1:0]     a_op, b_op, alu_res, br_tgt;
  logic [SH_W-1:0]       shamt;
  logic [REG_ADDR_W-1:0] dest;
  logic                  accept, md_start, md_busy, md_done_c;
  logic [DATA_W-1:0]     md_hi, md_lo, md_lo_nxt;

  logic                  out_valid_q, out_valid_d, regwrite_q, regwrite_d, zero_q, zero_d;
  logic [DATA_W-1:0]     alu_result_q, alu_result_d, pcb_q, pcb_d;
  logic [REG_ADDR_W-1:0] regdest_q, regdest_d, mul_dest_q, mul_dest_d;
  logic                  mul_pend_q, mul_pend_d, mul_wr_q, mul_wr_d;

  assign alu_op   = decode(Opcode, Funct);
  assign accept   = in_valid & ~Flush & ~md_busy;
  assign md_start = accept & (is_mul(alu_op) | is_div(alu_op));
  assign dest     = RegDst ? rd : rt;
  assign br_tgt   = PC_Plus4 + (Imm32b << 2);
  assign a_op     = ALUSrcA ? DATA_W'(sa) : Reg_Data1;
  assign shamt    = a_op[SH_W-1:0];

  always_comb begin
    b_op = '0;
    case (ALUSrcB)
      2'd0:    b_op = Reg_Data2;
      2'd1:    b_op = Imm32b;
      2'd2:    b_op = DATA_W'(8);
      default: b_op = '0;
    endcase
  end

  // Single-cycle ALU; mul/div encodings and unknown ops yield 0.
  always_comb begin
    alu_res = '0;
    case (alu_op)
      ALU_ADD:  alu_res = a_op + b_op;
      ALU_SUB:  alu_res = a_op - b_op;
      ALU_AND:  alu_res = a_op & b_op;
      ALU_OR:   alu_res = a_op | b_op;
      ALU_XOR:  alu_res = a_op ^ b_op;
      ALU_NOR:  alu_res = ~(a_op | b_op);
      ALU_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(a_op) < $signed(b_op))};
      ALU_SLTU: alu_res = {{(DATA_W-1){1'b0}}, (a_op < b_op)};
      ALU_SLL:  alu_res = b_op << shamt;
      ALU_SRL:  alu_res = b_op >> shamt;
      ALU_SRA:  alu_res = DATA_W'($signed(b_op) >>> shamt);
      ALU_LUI:  alu_res = b_op << 16;
      ALU_MFHI: alu_res = md_hi;
      ALU_MFLO: alu_res = md_lo;
      default:  alu_res = '0;
    endcase
  end

  ex_muldiv_unit #(
    .DATA_W     (DATA_W),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_muldiv (
    .clk      (Clk),
    .rst_n    (Reset),
    .start    (md_start),
    .op       (alu_op),
    .opa      (a_op),
    .opb      (b_op),
    .busy     (md_busy),
    .done_c   (md_done_c),
    .hi       (md_hi),
    .lo       (md_lo),
    .lo_nxt_c (md_lo_nxt)
  );

  // EX/MEM register: data holds unless an instruction is accepted or a MUL retires.
  always_comb begin
    out_valid_d  = 1'b0;
    regwrite_d   = 1'b0;
    alu_result_d = alu_result_q;
    pcb_d        = pcb_q;
    zero_d       = zero_q;
    regdest_d    = regdest_q;
    mul_pend_d   = mul_pend_q;
    mul_dest_d   = mul_dest_q;
    mul_wr_d     = mul_wr_q;

    if (accept) begin
      if (alu_op == ALU_MUL) begin
        mul_pend_d = 1'b1;
        mul_dest_d = dest;
        mul_wr_d   = RegWrite;
      end else begin
        out_valid_d  = 1'b1;
        alu_result_d = alu_res;
        pcb_d        = br_tgt;
        zero_d       = (alu_res == '0);
        regdest_d    = dest;
        regwrite_d   = RegWrite & ~(is_mul(alu_op) | is_div(alu_op));
      end
    end else if (mul_pend_q && md_done_c) begin
      out_valid_d  = 1'b1;
      alu_result_d = md_lo_nxt;
      zero_d       = (md_lo_nxt == '0);
      regdest_d    = mul_dest_q;
      regwrite_d   = mul_wr_q;
      mul_pend_d   = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      out_valid_q  <= 1'b0;
      regwrite_q   <= 1'b0;
      alu_result_q <= '0;
      pcb_q        <= '0;
      zero_q       <= 1'b0;
      regdest_q    <= '0;
      mul_pend_q   <= 1'b0;
      mul_dest_q   <= '0;
      mul_wr_q     <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      regwrite_q   <= regwrite_d;
      alu_result_q <= alu_result_d;
      pcb_q        <= pcb_d;
      zero_q       <= zero_d;
      regdest_q    <= regdest_d;
      mul_pend_q   <= mul_pend_d;
      mul_dest_q   <= mul_dest_d;
      mul_wr_q     <= mul_wr_d;
    end
  end

  assign Stall              = md_busy;
  assign out_valid          = out_valid_q;
  assign RegWrite_out       = regwrite_q;
  assign ALUResult_out      = alu_result_q;
  assign PC_Plus_Branch_out = pcb_q;
  assign Zero_out           = zero_q;
  assign RegDest_out        = regdest_q;

endmodule

// File: tb/tb_ex_stage_muldiv.sv
// Directed bench for ex_stage_muldiv with hand-computed expected values.
module tb_ex_stage_muldiv;

  logic        Clk;
  logic        Reset;
  logic        in_valid, Flush;
  logic [5:0]  Opcode, Funct;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic        RegDst, RegWrite;
  logic [31:0] Reg_Data1, Reg_Data2, Imm32b, PC_Plus4;
  logic [4:0]  sa, rt, rd;
  logic        Stall, out_valid, Zero_out, RegWrite_out;
  logic [31:0] ALUResult_out, PC_Plus_Branch_out;
  logic [4:0]  RegDest_out;

  int n_vec = 0;
  int n_err = 0;
  int n_cyc = 0;
  int ov_cnt = 0;

  ex_stage_muldiv #(
    .DATA_W     (32),
    .REG_ADDR_W (5),
    .MUL_CYCLES (4)
  ) dut (
    .Clk                (Clk),
    .Reset              (Reset),
    .in_valid           (in_valid),
    .Flush              (Flush),
    .Opcode             (Opcode),
    .Funct              (Funct),
    .ALUSrcA            (ALUSrcA),
    .ALUSrcB            (ALUSrcB),
    .RegDst             (RegDst),
    .RegWrite           (RegWrite),
    .Reg_Data1          (Reg_Data1),
    .Reg_Data2          (Reg_Data2),
    .Imm32b             (Imm32b),
    .PC_Plus4           (PC_Plus4),
    .sa                 (sa),
    .rt                 (rt),
    .rd                 (rd),
    .Stall              (Stall),
    .out_valid          (out_valid),
    .ALUResult_out      (ALUResult_out),
    .PC_Plus_Branch_out (PC_Plus_Branch_out),
    .Zero_out           (Zero_out),
    .RegDest_out        (RegDest_out),
    .RegWrite_out       (RegWrite_out)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic clr();
    in_valid  = 1'b0; Flush    = 1'b0;
    Opcode    = '0;   Funct    = '0;
    ALUSrcA   = 1'b0; ALUSrcB  = '0;
    RegDst    = 1'b0; RegWrite = 1'b0;
    Reg_Data1 = '0;   Reg_Data2 = '0;
    Imm32b    = '0;   PC_Plus4  = '0;
    sa        = '0;   rt = '0; rd = '0;
  endtask

  task automatic fire();
    in_valid = 1'b1;
    @(posedge Clk); #1;
    in_valid = 1'b0;
  endtask

  // Counts edges until Stall drops (bounded); also counts out_valid seen while stalled.
  task automatic wait_idle();
    n_cyc  = 0;
    ov_cnt = 0;
    while (Stall === 1'b1 && n_cyc < 200) begin
      if (out_valid === 1'b1) ov_cnt++;
      @(posedge Clk); #1;
      n_cyc++;
    end
  endtask

  task automatic read_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    clr(); Funct = 6'h10; fire();
    chk({tag, "_mfhi"}, ALUResult_out, exp_hi);
    clr(); Funct = 6'h12; fire();
    chk({tag, "_mflo"}, ALUResult_out, exp_lo);
  endtask

  initial begin
    clr();
    Reset = 1'b0;
    #12;
    chk1("rst_stall", Stall, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_regwrite", RegWrite_out, 1'b0);
    chk("rst_alu", ALUResult_out, 32'h0);
    chk("rst_pcb", PC_Plus_Branch_out, 32'h0);
    chk1("rst_zero", Zero_out, 1'b0);
    chk({27'b0, RegDest_out} === 32'h0 ? "rst_regdest" : "rst_regdest", {27'b0, RegDest_out}, 32'h0);
    Reset = 1'b1;
    @(posedge Clk); #1;

    // ADDI 5 + 0xFFFFFFFF wraps to 4; branch target 0x100 + 0xFFFFFFFC
    clr(); Opcode = 6'h08; Reg_Data1 = 32'd5; Imm32b = 32'hFFFF_FFFF; ALUSrcB = 2'd1;
    PC_Plus4 = 32'h100; rt = 5'd3; RegWrite = 1'b1; fire();
    chk("addi_res", ALUResult_out, 32'd4);
    chk1("addi_zero", Zero_out, 1'b0);
    chk1("addi_valid", out_valid, 1'b1);
    chk("addi_pcb", PC_Plus_Branch_out, 32'h0000_00FC);
    chk("addi_dest", {27'b0, RegDest_out}, 32'd3);
    chk1("addi_wr", RegWrite_out, 1'b1);

    clr(); @(posedge Clk); #1;
    chk1("idle_valid", out_valid, 1'b0);
    chk1("idle_wr", RegWrite_out, 1'b0);
    chk("idle_hold", ALUResult_out, 32'd4);

    clr(); Funct = 6'h03; ALUSrcA = 1'b1; sa = 5'd4; Reg_Data2 = 32'h8000_0000;
    RegDst = 1'b1; rd = 5'd2; RegWrite = 1'b1; fire();
    chk("sra_res", ALUResult_out, 32'hF800_0000);
    chk("sra_dest", {27'b0, RegDest_out}, 32'd2);

    clr(); Funct = 6'h2B; Reg_Data1 = 32'd1; Reg_Data2 = 32'hFFFF_FFFF; fire();
    chk("sltu_res", ALUResult_out, 32'd1);
    clr(); Funct = 6'h2A; Reg_Data1 = 32'd1; Reg_Data2 = 32'hFFFF_FFFF; fire();
    chk("slt_res", ALUResult_out, 32'd0);
    chk1("slt_zero", Zero_out, 1'b1);

    clr(); Opcode = 6'h04; Reg_Data1 = 32'h1234; Reg_Data2 = 32'h1234; Imm32b = 32'd4;
    PC_Plus4 = 32'h200; fire();
    chk("beq_res", ALUResult_out, 32'd0);
    chk1("beq_zero", Zero_out, 1'b1);
    chk("beq_pcb", PC_Plus_Branch_out, 32'h210);

    clr(); Opcode = 6'h0F; ALUSrcB = 2'd1; Imm32b = 32'h1234; fire();
    chk("lui_res", ALUResult_out, 32'h1234_0000);

    clr(); Funct = 6'h20; Reg_Data1 = 32'h10; ALUSrcB = 2'd2; RegDst = 1'b1; rd = 5'd9;
    RegWrite = 1'b1; fire();
    chk("add8_res", ALUResult_out, 32'h18);
    chk("add8_dest", {27'b0, RegDest_out}, 32'd9);

    clr(); Funct = 6'h20; Reg_Data1 = 32'd1; Reg_Data2 = 32'd1; RegWrite = 1'b1; Flush = 1'b1; fire();
    chk1("flush_valid", out_valid, 1'b0);
    chk1("flush_wr", RegWrite_out, 1'b0);
    chk("flush_hold", ALUResult_out, 32'h18);

    read_hilo("post_rst", 32'h0, 32'h0);

    // MULT -1 * 2 signed; MFHI held during the stall, accepted on the first free cycle
    clr(); Funct = 6'h18; Reg_Data1 = 32'hFFFF_FFFF; Reg_Data2 = 32'd2; RegWrite = 1'b1; fire();
    chk1("mult_bubble_valid", out_valid, 1'b1);
    chk1("mult_bubble_wr", RegWrite_out, 1'b0);
    chk1("mult_stall", Stall, 1'b1);
    clr(); Funct = 6'h10; RegWrite = 1'b1; in_valid = 1'b1;
    wait_idle();
    chk("mult_stall_cycles", n_cyc, 32'd4);
    @(posedge Clk); #1;
    in_valid = 1'b0;
    chk1("mfhi_held_valid", out_valid, 1'b1);
    chk("mfhi_held_res", ALUResult_out, 32'hFFFF_FFFF);
    clr(); Funct = 6'h12; fire();
    chk("mult_mflo", ALUResult_out, 32'hFFFF_FFFE);

    clr(); Funct = 6'h1A; Reg_Data1 = 32'hFFFF_FFF9; Reg_Data2 = 32'd2; fire();
    chk1("div_stall", Stall, 1'b1);
    clr(); wait_idle();
    chk("div_stall_cycles", n_cyc, 32'd32);
    read_hilo("div_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    clr(); Funct = 6'h1B; Reg_Data1 = 32'd9; Reg_Data2 = 32'd0; fire();
    clr(); wait_idle();
    chk("divu0_cycles", n_cyc, 32'd32);
    read_hilo("divu_9_0", 32'd9, 32'hFFFF_FFFF);

    clr(); Funct = 6'h1A; Reg_Data1 = 32'h8000_0000; Reg_Data2 = 32'hFFFF_FFFF; fire();
    clr(); wait_idle();
    read_hilo("div_min_m1", 32'h0, 32'h8000_0000);

    // MUL 3*4 to rd 7, with a flushed instruction presented throughout the busy period
    clr(); Opcode = 6'h1C; Funct = 6'h02; Reg_Data1 = 32'd3; Reg_Data2 = 32'd4;
    RegDst = 1'b1; rd = 5'd7; RegWrite = 1'b1; fire();
    chk1("mul_acc_stall", Stall, 1'b1);
    chk1("mul_acc_valid", out_valid, 1'b0);
    clr(); Funct = 6'h20; Reg_Data1 = 32'd1; RegWrite = 1'b1; rd = 5'd1; in_valid = 1'b1; Flush = 1'b1;
    wait_idle();
    chk("mul_busy_valids", ov_cnt, 32'd0);
    chk("mul_stall_cycles", n_cyc, 32'd4);
    chk1("mul_done_valid", out_valid, 1'b1);
    chk("mul_done_res", ALUResult_out, 32'd12);
    chk("mul_done_dest", {27'b0, RegDest_out}, 32'd7);
    chk1("mul_done_wr", RegWrite_out, 1'b1);
    chk1("mul_done_zero", Zero_out, 1'b0);
    @(posedge Clk); #1;
    chk1("mul_after_flush_valid", out_valid, 1'b0);
    read_hilo("mul_3_4", 32'h0, 32'd12);

    // Reset dropped right after a DIVU is accepted
    clr(); Funct = 6'h1B; Reg_Data1 = 32'd100; Reg_Data2 = 32'd7; RegDst = 1'b1; rd = 5'd5; fire();
    chk1("div_rst_pre_stall", Stall, 1'b1);
    chk1("div_rst_pre_valid", out_valid, 1'b1);
    #2; Reset = 1'b0; #1;
    chk1("div_rst_stall", Stall, 1'b0);
    chk1("div_rst_valid", out_valid, 1'b0);
    chk("div_rst_dest", {27'b0, RegDest_out}, 32'd0);
    #3; Reset = 1'b1;
    @(posedge Clk); #1;
    chk1("div_rst_after_stall", Stall, 1'b0);
    read_hilo("after_rst", 32'h0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
